// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - Bus bundle between the E stage and the multiply/divide unit
//
// Members:
//   start  - qualifies a write-type md_op this cycle
//   md_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
//   A, B   - rs / rt operands
//   busy   - multi-cycle operation in flight
//   MDout  - mfhi/mflo read value (0 for any other md_op)
//   HI, LO - current HI/LO registers
// Modports: master drives the operation, slave is the mdu itself.

interface mdu_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] MDout;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B,
        input  busy, MDout, HI, LO
    );

    modport slave (
        input  start, md_op, A, B,
        output busy, MDout, HI, LO
    );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - Multiply/divide unit with HI/LO registers and fixed-latency busy window
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - mdu_if.slave: start/md_op/A/B in, busy/MDout/HI/LO out
// Parameters:
//   MULT_CYCLES - busy cycles for mult/multu (>= 1)
//   DIV_CYCLES  - busy cycles for div/divu (>= 1)

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Counter only ever holds N-1, so clog2(N) bits suffice.
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_valid;

    logic          accept;
    logic          is_long_op;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   divisor;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   quot;
    logic [31:0]   remd;

    // Only write-type ops are accepted, and only while idle.
    assign accept     = bus.start && (state_q == IDLE) &&
                        (bus.md_op >= OP_MULT) && (bus.md_op <= OP_MTLO);
    assign is_long_op = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);

    // Results are computed at accept time and parked in the pending registers;
    // the busy window only models pipeline latency.
    always_comb begin
        prod_s  = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_u  = {32'd0, bus.A} * {32'd0, bus.B};

        a_neg   = 1'b0;
        b_neg   = 1'b0;
        if (bus.md_op == OP_DIV) begin
            a_neg = bus.A[31];
            b_neg = bus.B[31];
        end
        a_mag   = a_neg ? (~bus.A + 32'd1) : bus.A;
        b_mag   = b_neg ? (~bus.B + 32'd1) : bus.B;
        // Substitute 1 for a zero divisor; the result is discarded anyway.
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
        quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        remd    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && is_long_op) state_d = RUN;
            RUN:  if (cnt_q == '0)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi    <= 32'd0;
            pend_lo    <= 32'd0;
            pend_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (accept) begin
                    case (bus.md_op)
                        OP_MULT: begin
                            {pend_hi, pend_lo} <= prod_s;
                            pend_valid         <= 1'b1;
                            cnt_q              <= MULT_LOAD;
                        end
                        OP_MULTU: begin
                            {pend_hi, pend_lo} <= prod_u;
                            pend_valid         <= 1'b1;
                            cnt_q              <= MULT_LOAD;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi    <= remd;
                            pend_lo    <= quot;
                            pend_valid <= (bus.B != 32'd0);
                            cnt_q      <= DIV_LOAD;
                        end
                        OP_MTHI: hi_q <= bus.A;
                        OP_MTLO: lo_q <= bus.A;
                        default: ;
                    endcase
                end
            end else begin
                if (cnt_q == '0) begin
                    if (pend_valid) begin
                        hi_q <= pend_hi;
                        lo_q <= pend_lo;
                    end
                    pend_valid <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.MDout = (bus.md_op == OP_MFHI) ? hi_q :
                       (bus.md_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - Randomized and directed bench for mdu against a behavioural model

module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mdu_if bus();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit run_checks = 1'b0;

    // Behavioural model: remaining busy cycles plus architectural HI/LO.
    int          m_rem = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    bit          m_pok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            4'd1, 4'd2: begin
                p = (op == 4'd1) ? sa * sb : ua * ub;
                m_phi = p[63:32];
                m_plo = p[31:0];
                m_pok = 1'b1;
                m_rem = MC;
            end
            4'd3, 4'd4: begin
                m_rem = DC;
                if (b == 32'd0) m_pok = 1'b0;
                else begin
                    q = (op == 4'd3) ? sa / sb : ua / ub;
                    r = (op == 4'd3) ? sa % sb : ua % ub;
                    m_plo = q[31:0];
                    m_phi = r[31:0];
                    m_pok = 1'b1;
                end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem = 0;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            m_pok = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pok) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (bus.start) begin
            model_accept(bus.md_op, bus.A, bus.B);
        end
    end

    function automatic logic [31:0] exp_mdout();
        if (bus.md_op == 4'd7) return m_hi;
        if (bus.md_op == 4'd8) return m_lo;
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        if (run_checks) begin
            chk("busy",  {31'd0, bus.busy}, {31'd0, (m_rem > 0)});
            chk("HI",    bus.HI,    m_hi);
            chk("LO",    bus.LO,    m_lo);
            chk("MDout", bus.MDout, exp_mdout());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = s;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, op, a, b);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_idle();
        int n;
        count_busy(n);
        chk("idle_bound", {31'd0, bus.busy}, 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        #1 reset = 1'b0;
        tick();
        run_checks = 1'b1;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_HI", bus.HI, 32'd0);
        chk("rst_LO", bus.LO, 32'd0);
        bus.md_op = 4'd7;
        #1 chk("rst_mfhi", bus.MDout, 32'd0);
        bus.md_op = 4'd0;
        tick();
        reset = 1'b1;
        tick();

        do_op(4'd1, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        chk("mult_busy_len", n, 5);
        chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
        chk("mult_LO", bus.LO, 32'hFFFF_FFFE);

        do_op(4'd2, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        chk("multu_busy_len", n, 5);
        chk("multu_HI", bus.HI, 32'h0000_0001);
        chk("multu_LO", bus.LO, 32'hFFFF_FFFE);

        do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        chk("div_busy_len", n, 10);
        chk("div_LO", bus.LO, 32'hFFFF_FFFD);
        chk("div_HI", bus.HI, 32'hFFFF_FFFF);

        do_op(4'd4, 32'd7, 32'd2);
        wait_idle();
        chk("divu_LO", bus.LO, 32'd3);
        chk("divu_HI", bus.HI, 32'd1);

        do_op(4'd5, 32'h1234_5678, 32'd0);
        chk("mthi_now", bus.HI, 32'h1234_5678);
        chk("mthi_nobusy", {31'd0, bus.busy}, 32'd0);
        do_op(4'd3, 32'd5, 32'd0);
        count_busy(n);
        chk("div0_busy_len", n, 10);
        chk("div0_HI", bus.HI, 32'h1234_5678);
        chk("div0_LO", bus.LO, 32'd3);

        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        chk("ovf_LO", bus.LO, 32'h8000_0000);
        chk("ovf_HI", bus.HI, 32'd0);

        do_op(4'd1, 32'd3, 32'd5);
        drive(1'b1, 4'd6, 32'h0000_AAAA, 32'd0);
        tick();
        drive(1'b1, 4'd3, 32'd100, 32'd7);
        tick();
        drive(1'b0, 4'd8, 32'd0, 32'd0);
        #1;
        chk("busy_mflo_old", bus.MDout, 32'h8000_0000);
        chk("busy_still", {31'd0, bus.busy}, 32'd1);
        bus.md_op = 4'd0;
        wait_idle();
        chk("after_LO", bus.LO, 32'd15);
        chk("after_HI", bus.HI, 32'd0);

        do_op(4'd6, 32'hDEAD_BEEF, 32'd0);
        bus.md_op = 4'd8;
        #1 chk("mflo_read", bus.MDout, 32'hDEAD_BEEF);
        bus.md_op = 4'd0;
        #1 chk("none_read", bus.MDout, 32'd0);

        do_op(4'd3, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_HI", bus.HI, 32'd0);
        chk("arst_LO", bus.LO, 32'd0);
        tick();
        // Reset release coincides with an mthi request.
        drive(1'b1, 4'd5, 32'h0000_0055, 32'd0);
        reset = 1'b1;
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("rel_mthi", bus.HI, 32'h0000_0055);
        for (int i = 0; i < 15; i++) tick();
        chk("no_late_LO", bus.LO, 32'd0);
        chk("no_late_HI", bus.HI, 32'h0000_0055);

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
            tick();
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        wait_idle();

        run_checks = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
